// File: rtl/uwasic_onboarding_justin_haase_pkg.sv
// Shared constants for the SPI-programmed 16-output driver tile:
// register addresses, register count, SPI frame width and PWM clock divider.
package uwasic_onboarding_justin_haase_pkg;

    localparam int CLK_DIV  = 13;
    localparam int NUM_REGS = 5;
    localparam int FRAME_W  = 16;
    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int BCNT_W   = $clog2(FRAME_W + 2);

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

endpackage

// File: rtl/uwasic_onboarding_justin_haase_spi.sv
// SPI mode-0 write-only peripheral: input synchronizers, 16-bit shifter,
// commit-on-nCS-rise rule and the five control registers.
module uwasic_onboarding_justin_haase_spi
    import uwasic_onboarding_justin_haase_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        copi_i,
    input  logic        ncs_i,
    output logic [15:0] en_out_o,
    output logic [15:0] en_pwm_o,
    output logic [7:0]  duty_o
);

    // [1] is the synchronized level, [2] the previous synchronized level
    logic [2:0]         sclk_q;
    logic [1:0]         copi_q;
    logic [2:0]         ncs_q;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [15:0]        en_out_q, en_out_d;
    logic [15:0]        en_pwm_q, en_pwm_d;
    logic [7:0]         duty_q, duty_d;

    logic sclk_rise, ncs_rise, ncs_fall, commit;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
    assign ncs_fall  = ~ncs_q[1] & ncs_q[2];

    assign commit = ncs_rise
                  && (bcnt_q == BCNT_W'(FRAME_W))
                  && shift_q[15]
                  && (shift_q[14:8] < 7'(NUM_REGS));

    always_comb begin
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        en_out_d = en_out_q;
        en_pwm_d = en_pwm_q;
        duty_d   = duty_q;

        if (ncs_fall) begin
            shift_d = '0;
            bcnt_d  = '0;
        end else if (!ncs_q[1] && sclk_rise) begin
            shift_d = {shift_q[FRAME_W-2:0], copi_q[1]};
            // stops at FRAME_W+1 so any long frame stays distinguishable
            if (bcnt_q <= BCNT_W'(FRAME_W))
                bcnt_d = bcnt_q + BCNT_W'(1);
        end

        if (commit) begin
            case (shift_q[14:8])
                ADDR_EN_OUT_LO: en_out_d[7:0]  = shift_q[7:0];
                ADDR_EN_OUT_HI: en_out_d[15:8] = shift_q[7:0];
                ADDR_EN_PWM_LO: en_pwm_d[7:0]  = shift_q[7:0];
                ADDR_EN_PWM_HI: en_pwm_d[15:8] = shift_q[7:0];
                ADDR_DUTY:      duty_d         = shift_q[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            sclk_q   <= '0;
            copi_q   <= '0;
            ncs_q    <= '1;
            shift_q  <= '0;
            bcnt_q   <= '0;
            en_out_q <= '0;
            en_pwm_q <= '0;
            duty_q   <= '0;
        end else begin
            sclk_q   <= {sclk_q[1:0], sclk_i};
            copi_q   <= {copi_q[0], copi_i};
            ncs_q    <= {ncs_q[1:0], ncs_i};
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            en_out_q <= en_out_d;
            en_pwm_q <= en_pwm_d;
            duty_q   <= duty_d;
        end
    end

    assign en_out_o = en_out_q;
    assign en_pwm_o = en_pwm_q;
    assign duty_o   = duty_q;

endmodule

// File: rtl/uwasic_onboarding_justin_haase.sv
// Tiny Tapeout tile top: SPI register block, shared 8-bit PWM generator and
// registered 16-bit output mux (off / static high / PWM per bit).
module uwasic_onboarding_justin_haase
    import uwasic_onboarding_justin_haase_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [15:0]      en_out, en_pwm;
    logic [7:0]       duty;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      out_q, out_d;
    logic             div_wrap, pwm;

    // rst_n is active-high despite its name; it is the tile's reset pin
    uwasic_onboarding_justin_haase_spi u_spi (
        .clk      (clk),
        .rst_i    (rst_n),
        .sclk_i   (ui_in[0]),
        .copi_i   (ui_in[1]),
        .ncs_i    (ui_in[2]),
        .en_out_o (en_out),
        .en_pwm_o (en_pwm),
        .duty_o   (duty)
    );

    always_comb begin
        div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
        cnt_d    = div_wrap ? cnt_q + 8'd1 : cnt_q;
        pwm      = (duty == 8'hFF) ? 1'b1 : (cnt_q < duty);
        out_d    = en_out & (~en_pwm | {16{pwm}});
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            div_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign uo_out  = out_q[7:0];
    assign uio_out = out_q[15:8];
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_justin_haase.sv
// Self-checking bench: bit-banged SPI frames against a register-map model,
// plus PWM period/duty measurement on output bit 0.
module tb_uwasic_onboarding_justin_haase;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic [4:0] ui_hi = 5'd0;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int total = 0;
    int bad = 0;

    logic [7:0] m [5];

    assign ui_in = {ui_hi, ncs, copi, sclk};

    always #5 clk = ~clk;

    uwasic_onboarding_justin_haase dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    task automatic model_clear();
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
    endtask

    task automatic model_apply(input logic [31:0] bits, input int n);
        if (n == 16 && bits[15] == 1'b1 && int'(bits[14:8]) <= 4)
            m[int'(bits[14:8])] = bits[7:0];
    endtask

    // Expected outputs from the register model; PWM-driven bits are only
    // predictable at the duty extremes, so they are masked otherwise.
    task automatic model_expect(output logic [15:0] ev, output logic [15:0] mk);
        logic [15:0] eo, ep;
        eo = {m[1], m[0]};
        ep = {m[3], m[2]};
        if (m[4] == 8'hFF) begin
            ev = eo;
            mk = 16'hFFFF;
        end else if (m[4] == 8'h00) begin
            ev = eo & ~ep;
            mk = 16'hFFFF;
        end else begin
            ev = eo & ~ep;
            mk = ~(eo & ep);
        end
    endtask

    task automatic spi_send(input logic [31:0] bits, input int n, input bit raise);
        @(negedge clk);
        ncs = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
        if (raise) begin
            repeat (3) @(negedge clk);
            ncs = 1'b1;
            model_apply(bits, n);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ncs = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (uo_out !== 8'h00) begin
            bad++; $display("FAIL reset_uo: got %h expected 00", uo_out);
        end
        total++;
        if (uio_out !== 8'h00) begin
            bad++; $display("FAIL reset_uio: got %h expected 00", uio_out);
        end
        total++;
        if (uio_oe !== 8'hFF) begin
            bad++; $display("FAIL reset_oe: got %h expected ff", uio_oe);
        end
        repeat (600) @(posedge clk);
        #1;
        total++;
        if ({uio_out, uo_out} !== 16'h0000 || uio_oe !== 8'hFF) begin
            bad++; $display("FAIL reset_idle: got %h/%h expected 0000/ff", {uio_out, uo_out}, uio_oe);
        end
    endtask

    task automatic test_static_enable();
        spi_send(32'h80F0, 16, 1'b1);
        total++;
        if (uo_out !== 8'hF0) begin
            bad++; $display("FAIL static_lo: got %h expected f0", uo_out);
        end
        spi_send(32'h81CC, 16, 1'b1);
        total++;
        if ({uio_out, uo_out} !== 16'hCCF0) begin
            bad++; $display("FAIL static_hi: got %h expected ccf0", {uio_out, uo_out});
        end
    endtask

    task automatic test_ignored_frames();
        logic [31:0] fr [4];
        int          len [4];
        fr[0] = 32'h00AA;  len[0] = 16;
        fr[1] = 32'hB0AA;  len[1] = 16;
        fr[2] = 32'h4055;  len[2] = 15;
        fr[3] = 32'h18055; len[3] = 17;
        for (int k = 0; k < 4; k++) begin
            spi_send(fr[k], len[k], 1'b1);
            total++;
            if ({uio_out, uo_out} !== 16'hCCF0) begin
                bad++;
                $display("FAIL ignored_%0d: got %h expected ccf0", k, {uio_out, uo_out});
            end
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] fr;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] ev, mk;
        int          n, sel;
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       addr = 7'($urandom_range(0, 4));
            else if (sel == 6) addr = 7'd5;
            else               addr = 7'($urandom_range(6, 127));
            sel = $urandom_range(0, 7);
            data = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            sel = $urandom_range(0, 5);
            n = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            fr = {16'd0, ($urandom_range(0, 4) != 0), addr, data};
            if (n == 17) fr = {fr[30:0], 1'($urandom)};
            if (n == 15) fr = {1'b0, fr[31:1]};
            uio_in = 8'($urandom);
            spi_send(fr, n, 1'b1);
            model_expect(ev, mk);
            total++;
            if ((({uio_out, uo_out} ^ ev) & mk) !== 16'h0000) begin
                bad++;
                $display("FAIL random_%0d frame=%h len=%0d: got %h expected %h mask %h",
                         k, fr, n, {uio_out, uo_out}, ev, mk);
            end
        end
    endtask

    task automatic test_pwm_50();
        int t, hi, lo;
        spi_send(32'h8001, 16, 1'b1);
        spi_send(32'h8100, 16, 1'b1);
        spi_send(32'h8201, 16, 1'b1);
        spi_send(32'h8300, 16, 1'b1);
        spi_send(32'h8480, 16, 1'b1);
        t = 0;
        while (uo_out[0] !== 1'b0 && t < 4000) begin @(posedge clk); #1; t++; end
        while (uo_out[0] !== 1'b1 && t < 8000) begin @(posedge clk); #1; t++; end
        hi = 0;
        while (uo_out[0] === 1'b1 && hi < 4000) begin @(posedge clk); #1; hi++; end
        lo = 0;
        while (uo_out[0] === 1'b0 && lo < 4000) begin @(posedge clk); #1; lo++; end
        total++;
        if (hi < 1651 || hi > 1677) begin
            bad++; $display("FAIL pwm50_high: got %0d expected 1664+-13", hi);
        end
        total++;
        if (hi + lo != 3328) begin
            bad++; $display("FAIL pwm50_period: got %0d expected 3328", hi + lo);
        end
        total++;
        if (uo_out[7:1] !== 7'd0 || uio_out !== 8'h00) begin
            bad++; $display("FAIL pwm50_others: got %h expected 000", {uio_out, uo_out[7:1]});
        end
    endtask

    task automatic test_duty_extremes();
        int ones, zeros;
        spi_send(32'h8400, 16, 1'b1);
        repeat (10) @(posedge clk);
        ones = 0;
        for (int c = 0; c < 2 * 3328 + 100; c++) begin
            @(posedge clk); #1;
            if (uo_out[0] !== 1'b0) ones++;
        end
        total++;
        if (ones != 0) begin
            bad++; $display("FAIL duty00: got %0d high cycles expected 0", ones);
        end
        spi_send(32'h84FF, 16, 1'b1);
        repeat (10) @(posedge clk);
        zeros = 0;
        for (int c = 0; c < 2 * 3328 + 100; c++) begin
            @(posedge clk); #1;
            if (uo_out[0] !== 1'b1) zeros++;
        end
        total++;
        if (zeros != 0) begin
            bad++; $display("FAIL dutyff: got %0d low cycles expected 0", zeros);
        end
    endtask

    task automatic test_midframe_reset();
        spi_send(32'h81, 8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ncs = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({uio_out, uo_out} !== 16'h0000) begin
            bad++; $display("FAIL midreset_clear: got %h expected 0000", {uio_out, uo_out});
        end
        spi_send(32'h8001, 16, 1'b1);
        total++;
        if (uo_out !== 8'h01) begin
            bad++; $display("FAIL midreset_uo: got %h expected 01", uo_out);
        end
        total++;
        if (uio_out !== 8'h00) begin
            bad++; $display("FAIL midreset_uio: got %h expected 00", uio_out);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_static_enable();
        test_ignored_frames();
        test_random_frames();
        test_pwm_50();
        test_duty_extremes();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
